// File: rtl/filt_pkg.sv
// Shared types and defaults for the frame-synchronous filter mode sequencer.
package filt_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GAUSS  = 2'd1,
        MODE_SOBEL  = 2'd2,
        MODE_RSVD   = 2'd3
    } filt_mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_COMMIT  = 2'd2
    } seq_state_e;

    // Filter routing selects; exactly one field is set at any time.
    typedef struct packed {
        logic bypass;
        logic gauss;
        logic sobel;
    } filt_sel_t;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned FCNT_W    = 16;

endpackage

// File: rtl/filt_frame_tick.sv
// Frame-end detection on the last active pixel and completed-frame counter.
module filt_frame_tick
    import filt_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               de_in,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic               frame_end_c,
    output logic [FCNT_W-1:0]  frame_cnt
);

    logic [FCNT_W-1:0] cnt_q;

    // Last active pixel of the frame; coordinates are meaningless while de_in is low.
    assign frame_end_c = de_in
                      && (x_in == COORD_W'(H_RES - 1))
                      && (y_in == COORD_W'(V_RES - 1));

    // Completed-frame counter, wraps naturally at full scale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (frame_end_c) begin
            cnt_q <= cnt_q + FCNT_W'(1);
        end
    end

    assign frame_cnt = cnt_q;

endmodule

// File: rtl/filt_mode_sequencer.sv
// Holds a requested filter mode in a shadow register and commits it only between
// frames, with an optional forced-bypass settle period and a pending timeout.
module filt_mode_sequencer
    import filt_pkg::*;
#(
    parameter int unsigned H_RES         = H_RES_DEF,
    parameter int unsigned V_RES         = V_RES_DEF,
    parameter int unsigned SETTLE_FRAMES = 1,
    parameter int unsigned TIMEOUT_CYC   = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_mode,
    output logic        cfg_ready,
    input  logic        de_in,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    output logic [1:0]  mode_active,
    output logic        sel_gauss,
    output logic        sel_sobel,
    output logic        filt_bypass,
    output logic        cfg_done,
    output logic        cfg_timeout,
    output logic        cfg_err,
    output logic [15:0] frame_cnt
);

    localparam int unsigned TO_W  = (TIMEOUT_CYC < 2)   ? 1 : $clog2(TIMEOUT_CYC);
    localparam int unsigned SET_W = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);

    logic             frame_end_c;
    logic             xfer_c;

    seq_state_e       state_q,   state_d;
    filt_mode_e       shadow_q,  shadow_d;
    filt_mode_e       mode_q,    mode_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
    logic             to_flag_q, to_flag_d;
    logic [SET_W-1:0] settle_q,  settle_d;
    filt_sel_t        sel_q,     sel_d;
    logic             ready_q;
    logic             done_q,    done_d;
    logic             tmo_q,     tmo_d;
    logic             err_q,     err_d;

    filt_frame_tick #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_tick (
        .clk         (clk),
        .reset       (reset),
        .de_in       (de_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .frame_end_c (frame_end_c),
        .frame_cnt   (frame_cnt)
    );

    assign xfer_c = cfg_valid && ready_q;

    // Next-state, shadow, timeout, settle and pulse logic.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        mode_d    = mode_q;
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        settle_d  = settle_q;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        err_d     = 1'b0;

        if (frame_end_c && (settle_q != '0)) begin
            settle_d = settle_q - SET_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (xfer_c) begin
                    state_d   = S_PENDING;
                    to_cnt_d  = '0;
                    to_flag_d = 1'b0;
                    if (filt_mode_e'(cfg_mode) == MODE_RSVD) begin
                        shadow_d = MODE_BYPASS;
                        err_d    = 1'b1;
                    end else begin
                        shadow_d = filt_mode_e'(cfg_mode);
                    end
                end
            end
            S_PENDING: begin
                if (frame_end_c) begin
                    state_d = S_COMMIT;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_COMMIT;
                    to_flag_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                mode_d  = shadow_q;
                done_d  = 1'b1;
                tmo_d   = to_flag_q;
                // Filter pipelines need flushing only when leaving bypass.
                if ((mode_q == MODE_BYPASS) && (shadow_q != MODE_BYPASS)) begin
                    settle_d = SET_W'(SETTLE_FRAMES);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sel_d.bypass = (mode_d == MODE_BYPASS) || (settle_d != '0);
        sel_d.gauss  = (mode_d == MODE_GAUSS)  && (settle_d == '0);
        sel_d.sobel  = (mode_d == MODE_SOBEL)  && (settle_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shadow_q  <= MODE_BYPASS;
            mode_q    <= MODE_BYPASS;
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
            settle_q  <= '0;
            sel_q     <= '{bypass: 1'b1, gauss: 1'b0, sobel: 1'b0};
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            mode_q    <= mode_d;
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
            settle_q  <= settle_d;
            sel_q     <= sel_d;
            ready_q   <= (state_d == S_IDLE);
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign mode_active = mode_q;
    assign filt_bypass = sel_q.bypass;
    assign sel_gauss   = sel_q.gauss;
    assign sel_sobel   = sel_q.sobel;
    assign cfg_done    = done_q;
    assign cfg_timeout = tmo_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_filt_mode_sequencer.sv
// Directed bench for filt_mode_sequencer on a small 8x4 frame with 2 blank cycles per line.
module tb_filt_mode_sequencer;
    import filt_pkg::*;

    localparam int H      = 8;
    localparam int V      = 4;
    localparam int SETTLE = 1;
    localparam int TO     = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [1:0]  cfg_mode;
    logic        cfg_ready;
    logic        de_in;
    logic [9:0]  x_in;
    logic [9:0]  y_in;
    logic [1:0]  mode_active;
    logic        sel_gauss;
    logic        sel_sobel;
    logic        filt_bypass;
    logic        cfg_done;
    logic        cfg_timeout;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    filt_mode_sequencer #(
        .H_RES         (H),
        .V_RES         (V),
        .SETTLE_FRAMES (SETTLE),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_mode    (cfg_mode),
        .cfg_ready   (cfg_ready),
        .de_in       (de_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .mode_active (mode_active),
        .sel_gauss   (sel_gauss),
        .sel_sobel   (sel_sobel),
        .filt_bypass (filt_bypass),
        .cfg_done    (cfg_done),
        .cfg_timeout (cfg_timeout),
        .cfg_err     (cfg_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] exp_mode;
        logic       exp_err;
        logic [2:0] exp_first;   // {bypass,gauss,sobel} in the frame after commit
        logic [2:0] exp_final;   // {bypass,gauss,sobel} one frame later
    } vec_t;

    vec_t vecs [8];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_seen, done_cyc, to_seen, to_cyc, err_seen, fe_cyc, onehot_bad;
    logic [1:0] snap_mode;
    logic [2:0] snap_sel;
    logic       ready_after;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cfg_done)    begin done_seen++; done_cyc = cyc; end
        if (cfg_timeout) begin to_seen++;   to_cyc   = cyc; end
        if (cfg_err)     err_seen++;
        if (!$onehot({filt_bypass, sel_gauss, sel_sobel})) onehot_bad++;
    endtask

    task automatic pix(input logic de, input int x, input int y);
        de_in = de;
        x_in  = 10'(x);
        y_in  = 10'(y);
        tick();
    endtask

    // One full frame; optionally raises a one-cycle request at pixel (rx,ry).
    task automatic frame(input bit req, input logic [1:0] m, input int rx, input int ry);
        bit fire;
        snap_mode   = mode_active;
        snap_sel    = {filt_bypass, sel_gauss, sel_sobel};
        done_seen   = 0;
        to_seen     = 0;
        err_seen    = 0;
        ready_after = 1'b1;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                fire = req && (x == rx) && (y == ry);
                if (fire) begin
                    cfg_valid = 1'b1;
                    cfg_mode  = m;
                end
                pix(1'b1, x, y);
                if ((x == H - 1) && (y == V - 1)) fe_cyc = cyc;
                if (fire) begin
                    cfg_valid   = 1'b0;
                    ready_after = cfg_ready;
                end
            end
            pix(1'b0, 0, 0);
            pix(1'b0, 0, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int k;
        logic [15:0] fc_before;

        vecs[0] = '{2'd1, 2'd1, 1'b0, 3'b100, 3'b010};  // bypass->gauss, settle frame
        vecs[1] = '{2'd2, 2'd2, 1'b0, 3'b001, 3'b001};  // gauss->sobel, no settle
        vecs[2] = '{2'd3, 2'd0, 1'b1, 3'b100, 3'b100};  // reserved -> bypass, err
        vecs[3] = '{2'd2, 2'd2, 1'b0, 3'b100, 3'b001};  // bypass->sobel, settle frame
        vecs[4] = '{2'd2, 2'd2, 1'b0, 3'b001, 3'b001};  // same mode
        vecs[5] = '{2'd1, 2'd1, 1'b0, 3'b010, 3'b010};  // sobel->gauss
        vecs[6] = '{2'd0, 2'd0, 1'b0, 3'b100, 3'b100};  // gauss->bypass, no settle
        vecs[7] = '{2'd0, 2'd0, 1'b0, 3'b100, 3'b100};  // same mode bypass

        reset = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0;
        de_in = 1'b0; x_in = '0; y_in = '0;
        done_seen = 0; done_cyc = 0; to_seen = 0; to_cyc = 0; err_seen = 0;
        fe_cyc = 0; onehot_bad = 0;
        tick(); tick();
        reset = 1'b0;

        // Reset state and idle frames.
        check("rst_mode",      int'(mode_active), 0);
        check("rst_sel",       int'({filt_bypass, sel_gauss, sel_sobel}), 3'b100);
        check("rst_ready",     int'(cfg_ready), 1);
        check("rst_pulses",    int'({cfg_done, cfg_timeout, cfg_err}), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        frame(1'b0, 2'd0, 0, 0);
        frame(1'b0, 2'd0, 0, 0);
        check("idle_frame_cnt", int'(frame_cnt), 2);
        check("idle_mode",      int'(mode_active), 0);
        check("idle_bypass",    int'(filt_bypass), 1);

        // Table of mid-frame requests.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d_ready_pre", i), int'(cfg_ready), 1);
            frame(1'b1, vecs[i].req, 2, 1);
            check($sformatf("v%0d_ready_pending", i), int'(ready_after), 0);
            check($sformatf("v%0d_done_cnt", i), done_seen, 1);
            check($sformatf("v%0d_done_lat", i), done_cyc - fe_cyc, 1);
            check($sformatf("v%0d_err", i), err_seen, int'(vecs[i].exp_err));
            check($sformatf("v%0d_timeout", i), to_seen, 0);
            frame(1'b0, 2'd0, 0, 0);
            check($sformatf("v%0d_mode", i), int'(snap_mode), int'(vecs[i].exp_mode));
            check($sformatf("v%0d_sel_first", i), int'(snap_sel), int'(vecs[i].exp_first));
            frame(1'b0, 2'd0, 0, 0);
            check($sformatf("v%0d_sel_final", i), int'(snap_sel), int'(vecs[i].exp_final));
        end

        // Request landing on the frame_end cycle waits for the following frame end.
        frame(1'b1, 2'd2, H - 1, V - 1);
        check("fe_req_ready", int'(ready_after), 0);
        check("fe_req_no_done", done_seen, 0);
        frame(1'b0, 2'd0, 0, 0);
        check("fe_req_mode_held", int'(snap_mode), 0);
        check("fe_req_done", done_seen, 1);
        check("fe_req_done_lat", done_cyc - fe_cyc, 1);
        frame(1'b0, 2'd0, 0, 0);
        check("fe_req_mode", int'(snap_mode), 2);
        check("fe_req_settle", int'(snap_sel), 3'b100);
        frame(1'b0, 2'd0, 0, 0);
        check("fe_req_sel", int'(snap_sel), 3'b001);

        // Timeout commit with no video.
        fc_before = frame_cnt;
        done_seen = 0; to_seen = 0; done_cyc = 0; to_cyc = 0;
        cfg_valid = 1'b1; cfg_mode = 2'd1;
        pix(1'b0, H - 1, V - 1);
        t0 = cyc;
        cfg_valid = 1'b0;
        k = 0;
        while ((done_seen == 0) && (k < 400)) begin
            pix(1'b0, H - 1, V - 1);
            k++;
        end
        check("to_done_lat",  done_cyc - t0, TO + 1);
        check("to_flag",      to_seen, 1);
        check("to_flag_cyc",  to_cyc - t0, TO + 1);
        check("to_sel",       int'({filt_bypass, sel_gauss, sel_sobel}), 3'b010);
        check("to_frame_cnt", int'(frame_cnt), int'(fc_before));

        // Reset while a request is pending.
        done_seen = 0;
        cfg_valid = 1'b1; cfg_mode = 2'd2;
        pix(1'b1, 0, 0);
        cfg_valid = 1'b0;
        pix(1'b1, 1, 0);
        pix(1'b1, 2, 0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready",     int'(cfg_ready), 1);
        check("mid_rst_mode",      int'(mode_active), 0);
        check("mid_rst_sel",       int'({filt_bypass, sel_gauss, sel_sobel}), 3'b100);
        check("mid_rst_frame_cnt", int'(frame_cnt), 0);
        pix(1'b0, 0, 0);
        reset = 1'b0;
        frame(1'b0, 2'd0, 0, 0);
        check("post_rst_no_done", done_seen, 0);
        check("post_rst_mode",    int'(mode_active), 0);
        check("post_rst_cnt",     int'(frame_cnt), 1);

        // Frame counter wrap from a preset full-scale value.
        force dut.u_tick.cnt_q = 16'hFFFF;
        pix(1'b0, 0, 0);
        release dut.u_tick.cnt_q;
        pix(1'b0, 0, 0);
        check("wrap_preset", int'(frame_cnt), 16'hFFFF);
        frame(1'b0, 2'd0, 0, 0);
        check("wrap_zero", int'(frame_cnt), 0);

        check("select_onehot_violations", onehot_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
